i2s_rx_deserializer: RTL and testbench

//  Slave-mode receive datapath. Consumes the channel state (L/R/IDLE) from the WS tracking

---
 rtl/i2s_rx_deserializer.sv | 149 ++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - I2S slave receive deserialiser with valid/ready word output
//
// Purpose: shifts each L/R channel slot in MSB-first. A completed word is
// handed to the RX buffer through a one-entry valid/ready output register.
// A word that arrives while the register is still full is dropped (ovf_o).
// A slot that ends before all of its bits arrive raises short_err_o.
//
// Ports:
//   clk_i        serial bit clock (SCK); sd_i is sampled on posedge
//   rst_ni       asynchronous active-low reset
//   en_i         receive enable (synchronous level)
//   state_i      channel state from the WS tracker: 0 IDLE, 1 L, 2 R
//   f32_i        1: 32-bit slots, 0: 16-bit slots; sampled at slot start
//   sd_i         serial data
//   rx_data_o    received word; 16-bit words are zero-extended
//   rx_left_o    1: word came from an L slot, 0: from an R slot
//   rx_valid_o   rx_data_o/rx_left_o hold a word
//   rx_ready_i   downstream accepts the word when rx_valid_o && rx_ready_i
//   ovf_o        1-cycle pulse: a completed word was dropped
//   short_err_o  1-cycle pulse: a slot ended before all its bits arrived
module i2s_rx_deserializer #(
   parameter int MAX_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [1:0]       state_i,
   input  logic             f32_i,
   input  logic             sd_i,
   output logic [MAX_W-1:0] rx_data_o,
   output logic             rx_left_o,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   output logic             ovf_o,
   output logic             short_err_o
);

   localparam logic [1:0] WS_IDLE = 2'd0;
   localparam logic [1:0] WS_L    = 2'd1;
   localparam logic [1:0] WS_R    = 2'd2;

   logic [1:0]       state_q,    state_d;
   logic [5:0]       bit_cnt_q,  bit_cnt_d;
   logic [5:0]       slot_w_q,   slot_w_d;
   logic [MAX_W-1:0] shift_q,    shift_d;
   logic             done_q,     done_d;
   logic [MAX_W-1:0] rx_data_q,  rx_data_d;
   logic             rx_left_q,  rx_left_d;
   logic             rx_valid_q, rx_valid_d;
   logic             ovf_q,      ovf_d;
   logic             short_q,    short_d;

   logic             in_slot;
   logic             slot_start;
   logic             partial;
   logic             complete;
   logic [5:0]       cnt_inc;
   logic [MAX_W-1:0] word;

   always_comb begin
      state_d    = state_i;
      bit_cnt_d  = bit_cnt_q;
      slot_w_d   = slot_w_q;
      shift_d    = shift_q;
      done_d     = done_q;
      rx_data_d  = rx_data_q;
      rx_left_d  = rx_left_q;
      rx_valid_d = rx_valid_q;
      ovf_d      = 1'b0;
      short_d    = 1'b0;
      complete   = 1'b0;

      in_slot    = (state_i == WS_L) || (state_i == WS_R);
      slot_start = (state_i != state_q) && in_slot && en_i;
      // a slot that received some bits but never completed
      partial    = (bit_cnt_q != 6'd0) && (bit_cnt_q < slot_w_q) && !done_q;
      cnt_inc    = bit_cnt_q + 6'd1;
      word       = {shift_q[MAX_W-2:0], sd_i};

      if (!en_i) begin
         // silent discard; done blocks shifting until the next slot_start
         bit_cnt_d = 6'd0;
         done_d    = 1'b1;
      end else if (slot_start) begin
         // clearing the upper bits here gives zero-extension of 16-bit words
         shift_d   = {{(MAX_W-1){1'b0}}, sd_i};
         bit_cnt_d = 6'd1;
         slot_w_d  = f32_i ? 6'd32 : 6'd16;
         done_d    = 1'b0;
         short_d   = partial;
      end else if (!in_slot) begin
         bit_cnt_d = 6'd0;
         done_d    = 1'b1;
         short_d   = partial;
      end else if (!done_q) begin
         shift_d   = word;
         bit_cnt_d = cnt_inc;
         if (cnt_inc == slot_w_q) begin
            done_d   = 1'b1;
            complete = 1'b1;
         end
      end

      if (complete) begin
         if (!rx_valid_q || rx_ready_i) begin
            rx_data_d  = word;
            rx_left_d  = (state_q == WS_L);
            rx_valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= WS_IDLE;
         bit_cnt_q  <= 6'd0;
         slot_w_q   <= 6'd16;
         shift_q    <= '0;
         done_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_left_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         short_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         slot_w_q   <= slot_w_d;
         shift_q    <= shift_d;
         done_q     <= done_d;
         rx_data_q  <= rx_data_d;
         rx_left_q  <= rx_left_d;
         rx_valid_q <= rx_valid_d;
         ovf_q      <= ovf_d;
         short_q    <= short_d;
      end
   end

   assign rx_data_o   = rx_data_q;
   assign rx_left_o   = rx_left_q;
   assign rx_valid_o  = rx_valid_q;
   assign ovf_o       = ovf_q;
   assign short_err_o = short_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - scoreboard testbench for i2s_rx_deserializer
module tb_i2s_rx_deserializer;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_L    = 2'd1;
   localparam logic [1:0] S_R    = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [1:0]  st = S_IDLE;
   logic        f32 = 1'b0;
   logic        sd = 1'b0;
   logic        rx_ready = 1'b0;
   logic [31:0] rx_data;
   logic        rx_left;
   logic        rx_valid;
   logic        ovf;
   logic        short_err;

   i2s_rx_deserializer #(.MAX_W(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .state_i     (st),
      .f32_i       (f32),
      .sd_i        (sd),
      .rx_data_o   (rx_data),
      .rx_left_o   (rx_left),
      .rx_valid_o  (rx_valid),
      .rx_ready_i  (rx_ready),
      .ovf_o       (ovf),
      .short_err_o (short_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [32:0] exp_q[$];       // {left, data} in delivery order
   bit          m_full = 1'b0;  // model: output register occupied
   int          ovf_exp = 0;
   int          short_exp = 0;
   int          ovf_seen = 0;
   int          short_seen = 0;
   int          rdy_pct = 100;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bit period; the model resolves what the coming posedge must do.
   task automatic tick(input logic [1:0] s, input logic sdv, input logic env, input logic fv,
                       input bit comp, input logic [32:0] ent);
      @(posedge clk);
      #1;
      st = s;
      sd = sdv;
      en = env;
      f32 = fv;
      rx_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      if (comp) begin
         if (!m_full || rx_ready) begin
            exp_q.push_back(ent);
            m_full = 1'b1;
         end else begin
            ovf_exp++;
         end
      end else if (m_full && rx_ready) begin
         m_full = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         tick(S_IDLE, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 33'h0);
   endtask

   // nbits: slot length in bit periods; en_drop: period where en falls (-1 = never)
   task automatic drive_slot(input logic [1:0] s, input bit w32, input logic [31:0] data,
                             input int nbits, input int en_drop, input bit count_short);
      int          sw;
      logic [32:0] ent;
      logic        sdv, env, fv;
      bit          comp;
      sw  = w32 ? 32 : 16;
      ent = {(s == S_L), (w32 ? data : {16'h0, data[15:0]})};
      for (int i = 0; i < nbits; i++) begin
         env  = (en_drop < 0) || (i < en_drop);
         sdv  = (i < sw) ? data[sw-1-i] : 1'($urandom_range(0, 1));
         fv   = (i == 0) ? w32 : 1'($urandom_range(0, 1));
         comp = (i == sw - 1) && ((en_drop < 0) || (en_drop >= sw));
         tick(s, sdv, env, fv, comp, ent);
      end
      if (count_short && en_drop < 0 && nbits < sw)
         short_exp++;
   endtask

   // Monitor: samples mid-cycle; a handshake completes on the next posedge.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ovf) ovf_seen++;
            if (short_err) short_seen++;
            if (rx_valid && rx_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_word: got %0h left %0b expected none", rx_data, rx_left);
               end else begin
                  e = exp_q.pop_front();
                  check("rx_data", 64'(rx_data), 64'(e[31:0]));
                  check("rx_left", 64'(rx_left), 64'(e[32]));
               end
            end
         end
      end
   end

   initial begin
      bit          w32;
      int          sw, nb, drop, k;
      logic [1:0]  ch;
      #2;
      check("rst_rx_data", 64'(rx_data), 64'h0);
      check("rst_rx_left", 64'(rx_left), 64'h0);
      check("rst_rx_valid", 64'(rx_valid), 64'h0);
      check("rst_ovf", 64'(ovf), 64'h0);
      check("rst_short_err", 64'(short_err), 64'h0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      idle(2);

      // stereo 32-bit
      rdy_pct = 100;
      drive_slot(S_L, 1'b1, 32'hA5A5_0F0F, 32, -1, 1'b1);
      drive_slot(S_R, 1'b1, 32'h1234_5678, 32, -1, 1'b1);
      // 16-bit slot with trailing bits
      drive_slot(S_L, 1'b0, 32'h0000_BEEF, 24, -1, 1'b1);
      // overflow: second word dropped, first held
      rdy_pct = 0;
      drive_slot(S_R, 1'b1, 32'hCAFE_F00D, 32, -1, 1'b1);
      drive_slot(S_L, 1'b1, 32'hDEAD_BEEF, 32, -1, 1'b1);
      rdy_pct = 100;
      drive_slot(S_R, 1'b0, 32'h0000_7A5C, 16, -1, 1'b1);
      // truncated slot then a normal one
      drive_slot(S_L, 1'b1, 32'h8765_4321, 10, -1, 1'b1);
      drive_slot(S_R, 1'b1, 32'h55AA_33CC, 32, -1, 1'b1);

      // reset mid-slot with a word held
      rdy_pct = 0;
      drive_slot(S_L, 1'b0, 32'h0000_C3A5, 16, -1, 1'b1);
      drive_slot(S_R, 1'b1, 32'h0BAD_CAFE, 10, -1, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_valid", 64'(rx_valid), 64'(m_full));
      rst_n = 1'b0;
      st = S_IDLE;
      #1;
      check("mid_rst_rx_data", 64'(rx_data), 64'h0);
      check("mid_rst_rx_left", 64'(rx_left), 64'h0);
      check("mid_rst_rx_valid", 64'(rx_valid), 64'h0);
      check("mid_rst_ovf", 64'(ovf), 64'h0);
      check("mid_rst_short_err", 64'(short_err), 64'h0);
      exp_q.delete();
      m_full = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rdy_pct = 100;
      idle(1);
      drive_slot(S_L, 1'b1, 32'h1357_9BDF, 32, -1, 1'b1);

      // enable dropped mid-slot, restored at the next slot
      drive_slot(S_R, 1'b1, 32'hFFFF_0000, 32, 12, 1'b1);
      drive_slot(S_L, 1'b1, 32'h0F1E_2D3C, 32, -1, 1'b1);

      // randomized slots, alternating channels
      ch = S_R;
      for (int n = 0; n < 60; n++) begin
         if (n % 10 == 0) begin
            k = int'($urandom_range(0, 3));
            rdy_pct = (k == 0) ? 100 : (k == 1) ? 70 : (k == 2) ? 30 : 0;
         end
         w32  = 1'($urandom_range(0, 1));
         sw   = w32 ? 32 : 16;
         k    = int'($urandom_range(0, 9));
         drop = -1;
         if (k < 6) begin
            nb = sw + int'($urandom_range(0, 4));
         end else if (k < 8) begin
            nb = int'($urandom_range(1, sw - 1));
         end else begin
            nb   = sw + int'($urandom_range(0, 3));
            drop = int'($urandom_range(1, nb - 1));
         end
         drive_slot(ch, w32, $urandom, nb, drop, 1'b1);
         ch = (ch == S_L) ? S_R : S_L;
         if ($urandom_range(0, 3) == 0)
            idle(int'($urandom_range(1, 2)));
      end

      rdy_pct = 100;
      idle(6);
      check("ovf_count", 64'(ovf_seen), 64'(ovf_exp));
      check("short_err_count", 64'(short_seen), 64'(short_exp));
      check("words_pending", 64'(exp_q.size()), 64'h0);
      check("final_rx_valid", 64'(rx_valid), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
